// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised integer register file.
// Defaults describe the RV32 configuration; modules override through parameters.
package regfile_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_idx_t;
  typedef logic [XLEN_DEF-1:0] reg_word_t;

  localparam int unsigned REG_ZERO = 0;
endpackage

// File: rtl/banco_registros_param_if.sv
// Read, write and issue signals of the register file, seen from decode/writeback
// (master) and from the register file itself (slave).
interface banco_registros_param_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
) ();
  localparam int AW = $clog2(NREGS);

  logic [NRD-1:0][AW-1:0]   read_reg;
  logic [NRD-1:0][XLEN-1:0] read_data;
  logic [NRD-1:0]           read_busy;
  logic [NWR-1:0][AW-1:0]   write_reg;
  logic [NWR-1:0][XLEN-1:0] write_data;
  logic [NWR-1:0]           RegWrite;
  logic [AW-1:0]            issue_reg;
  logic                     issue_en;
  logic                     any_busy;

  modport master (
    output read_reg, write_reg, write_data, RegWrite, issue_reg, issue_en,
    input  read_data, read_busy, any_busy
  );

  modport slave (
    input  read_reg, write_reg, write_data, RegWrite, issue_reg, issue_en,
    output read_data, read_busy, any_busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits: set on issue, cleared by a completing write;
// a same-edge issue wins over the clear because it belongs to a newer instruction.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int NWR      = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rsta,
  input  logic [NWR-1:0][$clog2(NREGS)-1:0]    write_reg,
  input  logic [NWR-1:0]                       RegWrite,
  input  logic [$clog2(NREGS)-1:0]             issue_reg,
  input  logic                                 issue_en,
  output logic [NREGS-1:0]                     busy,
  output logic                                 any_busy
);
  localparam int AW = $clog2(NREGS);

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
    if (ZERO_REG && (gi == REG_ZERO)) begin : g_zero
      assign busy[gi] = 1'b0;
    end else begin : g_track
      logic busy_reg;
      logic set_next;
      logic clr_next;

      always_comb begin
        clr_next = 1'b0;
        for (int p = 0; p < NWR; p++) begin
          if (RegWrite[p] && (write_reg[p] == AW'(gi))) clr_next = 1'b1;
        end
        set_next = issue_en && (issue_reg == AW'(gi));
      end

      always_ff @(posedge clk or negedge rsta) begin
        if (!rsta) busy_reg <= 1'b0;
        else       busy_reg <= set_next | (busy_reg & ~clr_next);
      end

      assign busy[gi] = busy_reg;
    end
  end

  assign any_busy = |busy;
endmodule

// File: rtl/banco_registros_param.sv
// Parametrised integer register file: NWR prioritised write ports, NRD combinational
// read ports with optional same-cycle forwarding, and a RAW busy scoreboard.
module banco_registros_param
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input logic                clk,
  input logic                rsta,
  banco_registros_param_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

  logic [NREGS-1:0][XLEN-1:0] regs_reg;
  logic [NREGS-1:0]           wr_en;
  logic [NREGS-1:0][XLEN-1:0] wr_data;
  logic [NREGS-1:0]           busy;

  // Later ports overwrite earlier ones, so the highest enabled index wins per register.
  always_comb begin
    wr_en   = '0;
    wr_data = '0;
    for (int p = 0; p < NWR; p++) begin
      if (bus.RegWrite[p]) begin
        wr_en[bus.write_reg[p]]   = 1'b1;
        wr_data[bus.write_reg[p]] = bus.write_data[p];
      end
    end
    if (ZERO_REG) wr_en[ZERO_IDX] = 1'b0;
  end

  always_ff @(posedge clk or negedge rsta) begin
    if (!rsta) begin
      regs_reg <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (wr_en[r]) regs_reg[r] <= wr_data[r];
      end
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [XLEN-1:0] rd_next;

    always_comb begin
      rd_next = regs_reg[bus.read_reg[gi]];
      if (BYPASS && wr_en[bus.read_reg[gi]]) rd_next = wr_data[bus.read_reg[gi]];
      if (ZERO_REG && (bus.read_reg[gi] == ZERO_IDX)) rd_next = '0;
    end

    assign bus.read_data[gi] = rd_next;
    // Busy is the registered state only; a write completing this cycle still reads busy.
    assign bus.read_busy[gi] = busy[bus.read_reg[gi]];
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rsta      (rsta),
    .write_reg (bus.write_reg),
    .RegWrite  (bus.RegWrite),
    .issue_reg (bus.issue_reg),
    .issue_en  (bus.issue_en),
    .busy      (busy),
    .any_busy  (bus.any_busy)
  );
endmodule

// File: tb/tb_banco_registros_param.sv
// Directed bench for banco_registros_param in its default RV32 configuration.
module tb_banco_registros_param;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rsta = 1'b0;
  int   checks = 0;
  int   errors = 0;

  banco_registros_param_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus ();

  banco_registros_param #(
    .XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1'b1), .ZERO_REG(1'b1)
  ) dut (
    .clk  (clk),
    .rsta (rsta),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input reg_word_t got, input reg_word_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic idle();
    bus.RegWrite   = '0;
    bus.write_reg  = '0;
    bus.write_data = '0;
    bus.issue_en   = 1'b0;
    bus.issue_reg  = '0;
  endtask

  task automatic wr(input int port, input reg_idx_t r, input reg_word_t d);
    bus.RegWrite[port]   = 1'b1;
    bus.write_reg[port]  = r;
    bus.write_data[port] = d;
  endtask

  task automatic rd(input reg_idx_t r0, input reg_idx_t r1);
    bus.read_reg[0] = r0;
    bus.read_reg[1] = r1;
    #1;
  endtask

  // Inputs change on the falling edge; checks land 1ns later, well before the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    bus.read_reg = '0;

    rd(5'd5, 5'd31);
    chk("reset_rd0_x5", bus.read_data[0], 32'h0);
    chk("reset_rd1_x31", bus.read_data[1], 32'h0);
    chk("reset_any_busy", 32'(bus.any_busy), 32'h0);

    @(negedge clk);
    rsta = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 32; r++) begin
      rd(reg_idx_t'(r), reg_idx_t'(31 - r));
      chk($sformatf("post_reset_rd0_x%0d", r), bus.read_data[0], 32'h0);
      chk($sformatf("post_reset_rd1_x%0d", 31 - r), bus.read_data[1], 32'h0);
      chk($sformatf("post_reset_busy_x%0d", r), 32'(bus.read_busy), 32'h0);
    end
    chk("post_reset_any_busy", 32'(bus.any_busy), 32'h0);

    // Same-cycle forwarding, then the stored value
    wr(0, 5'd5, 32'hDEADBEEF);
    rd(5'd5, 5'd6);
    chk("bypass_x5", bus.read_data[0], 32'hDEADBEEF);
    chk("bypass_other_x6", bus.read_data[1], 32'h0);
    next_cycle();
    rd(5'd5, 5'd6);
    chk("stored_x5", bus.read_data[0], 32'hDEADBEEF);

    // Port priority on the same register; distinct registers both land
    wr(0, 5'd7, 32'h11111111);
    wr(1, 5'd7, 32'h22222222);
    rd(5'd7, 5'd7);
    chk("prio_bypass_x7", bus.read_data[0], 32'h22222222);
    next_cycle();
    rd(5'd7, 5'd7);
    chk("prio_stored_x7", bus.read_data[1], 32'h22222222);
    wr(0, 5'd10, 32'h0000000A);
    wr(1, 5'd11, 32'h0000000B);
    next_cycle();
    rd(5'd10, 5'd11);
    chk("dual_x10", bus.read_data[0], 32'h0000000A);
    chk("dual_x11", bus.read_data[1], 32'h0000000B);

    // x0 is hardwired
    wr(1, 5'd0, 32'hFFFFFFFF);
    rd(5'd0, 5'd0);
    chk("x0_same_cycle", bus.read_data[0], 32'h0);
    next_cycle();
    rd(5'd0, 5'd0);
    chk("x0_after_edge", bus.read_data[1], 32'h0);
    chk("x0_busy", 32'(bus.read_busy), 32'h0);

    // Issue to x3, then complete it
    bus.issue_en  = 1'b1;
    bus.issue_reg = 5'd3;
    rd(5'd3, 5'd0);
    chk("issue_x3_not_yet", 32'(bus.read_busy[0]), 32'h0);
    next_cycle();
    rd(5'd3, 5'd0);
    chk("busy_x3", 32'(bus.read_busy[0]), 32'h1);
    chk("busy_x0_unaffected", 32'(bus.read_busy[1]), 32'h0);
    chk("any_busy_x3", 32'(bus.any_busy), 32'h1);
    wr(0, 5'd3, 32'h00000042);
    rd(5'd3, 5'd0);
    chk("busy_x3_no_clear_bypass", 32'(bus.read_busy[0]), 32'h1);
    chk("bypass_x3", bus.read_data[0], 32'h00000042);
    next_cycle();
    rd(5'd3, 5'd0);
    chk("cleared_x3", 32'(bus.read_busy[0]), 32'h0);
    chk("data_x3", bus.read_data[0], 32'h00000042);
    chk("any_busy_drained", 32'(bus.any_busy), 32'h0);

    // Issue x0 never sets busy
    bus.issue_en  = 1'b1;
    bus.issue_reg = 5'd0;
    next_cycle();
    rd(5'd0, 5'd3);
    chk("issue_x0_ignored", 32'(bus.any_busy), 32'h0);

    // Issue and complete x9 on the same edge: issue wins
    bus.issue_en  = 1'b1;
    bus.issue_reg = 5'd9;
    wr(0, 5'd9, 32'h00000005);
    next_cycle();
    rd(5'd9, 5'd5);
    chk("x9_data", bus.read_data[0], 32'h00000005);
    chk("x9_busy_kept", 32'(bus.read_busy[0]), 32'h1);
    chk("x5_still_held", bus.read_data[1], 32'hDEADBEEF);
    chk("any_busy_x9", 32'(bus.any_busy), 32'h1);

    // Mid-operation reset: immediate clear, and a write held across the edge is lost
    wr(0, 5'd12, 32'h12345678);
    rsta = 1'b0;
    bus.read_reg[0] = 5'd9;
    bus.read_reg[1] = 5'd5;
    #1;
    chk("rst_x9_data", bus.read_data[0], 32'h0);
    chk("rst_x9_busy", 32'(bus.read_busy[0]), 32'h0);
    chk("rst_x5_data", bus.read_data[1], 32'h0);
    chk("rst_any_busy", 32'(bus.any_busy), 32'h0);
    @(posedge clk);
    @(negedge clk);
    idle();
    rsta = 1'b1;
    rd(5'd12, 5'd7);
    chk("rst_write_lost_x12", bus.read_data[0], 32'h0);
    chk("rst_x7_cleared", bus.read_data[1], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
